// File: rtl/hs32_execute_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hs32_execute_if : L1 memory request bus from execute stage 3 to L1       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface hs32_execute_if;
  logic        vld;
  logic        rdy;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  rd;

  modport master (output vld, we, addr, wdata, rd, input rdy);
  modport slave  (input vld, we, addr, wdata, rd, output rdy);
endinterface
`default_nettype wire

// File: rtl/hs32_execute.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hs32_execute : HS32 stage 3 - ALU, NZCV flags, writeback / L1 request    |
// | Rev 1.0   optional stall counter: HS32_EXEC_STALLCNT_EN                  |
// +--------------------------------------------------------------------------+
module hs32_execute #(
  parameter logic [3:0] RST_FLAGS = 4'b0000
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         valid_i,
  input  wire  [81:0] data_i,
  output logic        stall_o,
  output logic [5:0]  s3_o,
  output logic [31:0] fwd_o,
  output logic [3:0]  flags_o,
  output logic        wb_vld_o,
  output logic [3:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  rp_addr_o,
  input  wire  [31:0] rp_data_i,
  hs32_execute_if.master mem
`ifdef HS32_EXEC_STALLCNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  input  wire         cnt_clr_i
`endif
);

  typedef struct packed {
    logic [1:0] opr;
    logic       neg;
    logic       sub;
    logic       cen;
    logic       fwe;
  } ctl_t;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        we1;
    logic        we2;
    logic [3:0]  rd;
    logic        store;
    logic        xud;
    logic        isldr;
    logic        isstr;
    logic [1:0]  fwd;
    ctl_t        ctl;
  } s2pkt_t;

  s2pkt_t      pkt_q;
  logic        vld_q;
  logic [3:0]  flags_q;
  logic [3:0]  flags_d;

  logic [31:0] b;
  logic        cin;
  logic [32:0] sum;
  logic [31:0] r;
  logic        c_d;
  logic        v_d;
  logic        lsu;
  logic        go;
  logic        fire;
  logic        retire;
  logic [31:0] res;
  logic        unused_pkt;

  always_comb begin
    b       = pkt_q.ctl.neg ? ~pkt_q.d2 : pkt_q.d2;
    cin     = pkt_q.ctl.cen ? flags_q[1] : pkt_q.ctl.sub;
    sum     = {1'b0, pkt_q.d1} + {1'b0, b} + {32'd0, cin};
    r       = sum[31:0];
    c_d     = flags_q[1];
    v_d     = flags_q[0];
    case (pkt_q.ctl.opr)
      2'd0: begin
        r   = sum[31:0];
        c_d = sum[32];
        v_d = (pkt_q.d1[31] == b[31]) & (sum[31] != pkt_q.d1[31]);
      end
      2'd1:    r = pkt_q.d1 & b;
      2'd2:    r = pkt_q.d1 | b;
      default: r = pkt_q.d1 ^ b;
    endcase
    flags_d = {r[31], (r == 32'd0), c_d, v_d};
  end

  // Strobes are also masked by rst_n so a discarded op never handshakes.
  assign go     = rst_n & vld_q;
  assign lsu    = pkt_q.isldr | pkt_q.isstr;
  assign stall_o = go & lsu & ~mem.rdy;
  assign fire   = ~stall_o;
  assign retire = go & (~lsu | mem.rdy);
  assign res    = vld_q ? r : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      flags_q <= RST_FLAGS;
    end else begin
      if (fire) begin
        pkt_q <= data_i;
        vld_q <= valid_i;
      end
      if (retire && pkt_q.ctl.fwe) begin
        flags_q <= flags_d;
      end
    end
  end

  assign fwd_o     = res;
  assign s3_o      = {(vld_q ? pkt_q.rd : 4'd0), go, go & lsu};
  assign flags_o   = flags_q;
  assign wb_vld_o  = go & ~lsu & pkt_q.we1;
  assign wb_rd_o   = vld_q ? pkt_q.rd : 4'd0;
  assign wb_data_o = res;
  assign rp_addr_o = vld_q ? pkt_q.rd : 4'd0;

  assign mem.vld   = go & lsu;
  assign mem.we    = go & pkt_q.isstr;
  assign mem.addr  = res;
  assign mem.wdata = vld_q ? rp_data_i : 32'd0;
  assign mem.rd    = vld_q ? pkt_q.rd : 4'd0;

  assign unused_pkt = ^{pkt_q.we2, pkt_q.store, pkt_q.xud, pkt_q.fwd};

`ifdef HS32_EXEC_STALLCNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr_i) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs32_execute.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hs32_execute : directed vector bench for hs32_execute                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hs32_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [81:0] data_i;
  logic        stall_o;
  logic [5:0]  s3_o;
  logic [31:0] fwd_o;
  logic [3:0]  flags_o;
  logic        wb_vld_o;
  logic [3:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [3:0]  rp_addr_o;
  logic [31:0] rp_data_i;
`ifdef HS32_EXEC_STALLCNT_EN
  logic [31:0] stall_cnt_o;
  logic        cnt_clr_i = 1'b0;
`endif

  always #5 clk = ~clk;

  hs32_execute_if mem_if ();

  hs32_execute #(.RST_FLAGS(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .stall_o   (stall_o),
    .s3_o      (s3_o),
    .fwd_o     (fwd_o),
    .flags_o   (flags_o),
    .wb_vld_o  (wb_vld_o),
    .wb_rd_o   (wb_rd_o),
    .wb_data_o (wb_data_o),
    .rp_addr_o (rp_addr_o),
    .rp_data_i (rp_data_i),
    .mem       (mem_if)
`ifdef HS32_EXEC_STALLCNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .cnt_clr_i   (cnt_clr_i)
`endif
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  opr;
    logic        neg;
    logic        sub;
    logic        cen;
    logic        fwe;
    logic        we1;
    logic [3:0]  rd;
    logic [31:0] exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   accepts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [81:0] mkpkt(input logic [31:0] d1, input logic [31:0] d2,
                                        input logic we1, input logic [3:0] rd,
                                        input logic ld, input logic st, input logic [1:0] opr,
                                        input logic neg, input logic sub, input logic cen,
                                        input logic fwe);
    return {d1, d2, we1, 1'b0, rd, 1'b0, 1'b0, ld, st, 2'b00, opr, neg, sub, cen, fwe};
  endfunction

  task automatic addv(input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] opr,
                      input logic neg, input logic sub, input logic cen, input logic fwe,
                      input logic we1, input logic [3:0] rd, input logic [31:0] er,
                      input logic [3:0] ef);
    vec_t v;
    v.d1 = d1; v.d2 = d2; v.opr = opr; v.neg = neg; v.sub = sub; v.cen = cen;
    v.fwe = fwe; v.we1 = we1; v.rd = rd; v.exp_r = er; v.exp_f = ef;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //   d1            d2            opr neg sub cen fwe we1 rd     exp_r         NZCV
    addv(32'hFFFFFFFF, 32'h00000001, 2'd0, 0, 0, 0, 1, 1, 4'd3,  32'h00000000, 4'b0110);
    addv(32'h00000005, 32'h00000005, 2'd0, 1, 1, 0, 1, 1, 4'd4,  32'h00000000, 4'b0110);
    addv(32'h00000001, 32'h00000001, 2'd0, 0, 0, 1, 1, 1, 4'd5,  32'h00000003, 4'b0000);
    addv(32'h80000000, 32'h80000000, 2'd0, 0, 0, 0, 1, 1, 4'd6,  32'h00000000, 4'b0111);
    addv(32'h000000FF, 32'h0000000F, 2'd1, 1, 0, 0, 1, 1, 4'd7,  32'h000000F0, 4'b0011);
    addv(32'h80000000, 32'h00000001, 2'd2, 0, 0, 0, 1, 1, 4'd8,  32'h80000001, 4'b1011);
    addv(32'hFFFF0000, 32'hFFFF0000, 2'd3, 0, 0, 0, 1, 1, 4'd9,  32'h00000000, 4'b0111);
    addv(32'h00000000, 32'h12345678, 2'd0, 0, 0, 0, 0, 1, 4'd10, 32'h12345678, 4'b0111);
    addv(32'h7FFFFFFF, 32'h00000001, 2'd0, 0, 0, 0, 0, 0, 4'd11, 32'h80000000, 4'b0111);
    addv(32'h0000000A, 32'h00000003, 2'd0, 1, 0, 1, 1, 1, 4'd12, 32'h00000007, 4'b0010);
    addv(32'h7FFFFFFF, 32'h00000001, 2'd0, 0, 0, 0, 1, 1, 4'd13, 32'h80000000, 4'b1001);
    addv(32'h0000000A, 32'h00000003, 2'd0, 1, 0, 1, 1, 1, 4'd14, 32'h00000006, 4'b0010);

    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; rp_data_i = '0; mem_if.rdy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #4;
    chk("rst stall", stall_o, 0);
    chk("rst wb_vld", wb_vld_o, 0);
    chk("rst mem_vld", mem_if.vld, 0);
    chk("rst flags", flags_o, 4'b0000);
    chk("rst s3", s3_o, 0);
    chk("rst fwd", fwd_o, 0);
    chk("rst addr", mem_if.addr, 0);
    tick();

    foreach (vq[i]) begin
      data_i = mkpkt(vq[i].d1, vq[i].d2, vq[i].we1, vq[i].rd, 1'b0, 1'b0, vq[i].opr,
                     vq[i].neg, vq[i].sub, vq[i].cen, vq[i].fwe);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      #4;
      chk($sformatf("v%0d wb_data", i), wb_data_o, vq[i].exp_r);
      chk($sformatf("v%0d fwd", i), fwd_o, vq[i].exp_r);
      chk($sformatf("v%0d wb_vld", i), wb_vld_o, vq[i].we1);
      chk($sformatf("v%0d wb_rd", i), wb_rd_o, vq[i].rd);
      tick();
      chk($sformatf("v%0d flags", i), flags_o, vq[i].exp_f);
      chk($sformatf("v%0d bubble wb_vld", i), wb_vld_o, 0);
    end

    // back-to-back SUB then ADC: ADC sees the C produced by SUB
    data_i = mkpkt(32'd5, 32'd5, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    valid_i = 1'b1;
    tick();
    data_i = mkpkt(32'd1, 32'd1, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    valid_i = 1'b0;
    #4;
    chk("b2b adc r", fwd_o, 32'd3);
    chk("b2b sub flags", flags_o, 4'b0110);
    tick();
    chk("b2b adc flags", flags_o, 4'b0000);

    // LDR held 3 cycles by mem_rdy_i low
    accepts = 0;
    data_i = mkpkt(32'h100, 32'h8, 1'b0, 4'd5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    valid_i = 1'b1;
    tick();
    data_i = mkpkt(32'd2, 32'd3, 1'b1, 4'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("ldr stall c%0d", k), stall_o, 1);
      chk($sformatf("ldr addr c%0d", k), mem_if.addr, 32'h108);
      chk($sformatf("ldr mem_vld c%0d", k), mem_if.vld, 1);
      chk($sformatf("ldr wb_vld c%0d", k), wb_vld_o, 0);
      if (mem_if.vld && mem_if.rdy) accepts++;
      tick();
    end
    chk("ldr we", mem_if.we, 0);
    chk("ldr rd", mem_if.rd, 4'd5);
    chk("ldr s3", s3_o, {4'd5, 1'b1, 1'b1});
    mem_if.rdy = 1'b1;
    #4;
    chk("ldr accept stall", stall_o, 0);
    chk("ldr accept vld", mem_if.vld, 1);
    chk("ldr accept addr", mem_if.addr, 32'h108);
    if (mem_if.vld && mem_if.rdy) accepts++;
    tick();
    valid_i = 1'b0;
    #4;
    chk("post-ldr mem_vld", mem_if.vld, 0);
    chk("post-ldr stall", stall_o, 0);
    chk("post-ldr wb_vld", wb_vld_o, 1);
    chk("post-ldr wb_data", wb_data_o, 32'd5);
    chk("post-ldr wb_rd", wb_rd_o, 4'd9);
    if (mem_if.vld && mem_if.rdy) accepts++;
    chk("ldr accept count", accepts, 1);
    tick();
    mem_if.rdy = 1'b0;

    // STR accepted in the cycle it is offered
    mem_if.rdy = 1'b1;
    rp_data_i = 32'hDEADBEEF;
    data_i = mkpkt(32'h200, 32'h4, 1'b0, 4'd2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    #4;
    chk("str vld", mem_if.vld, 1);
    chk("str we", mem_if.we, 1);
    chk("str wdata", mem_if.wdata, 32'hDEADBEEF);
    chk("str addr", mem_if.addr, 32'h204);
    chk("str stall", stall_o, 0);
    chk("str rp_addr", rp_addr_o, 4'd2);
    chk("str wb_vld", wb_vld_o, 0);
    tick();
    mem_if.rdy = 1'b0;

    // reset during a stalled LDR
    data_i = mkpkt(32'h80000000, 32'h80000000, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0,
                   1'b0, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b1;
    tick();
    data_i = mkpkt(32'h100, 32'h8, 1'b0, 4'd5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    valid_i = 1'b0;
    #4;
    chk("pre-rst flags", flags_o, 4'b0111);
    chk("pre-rst stall", stall_o, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #4;
    chk("midrst mem_vld", mem_if.vld, 0);
    chk("midrst s3 vld", s3_o[1], 0);
    chk("midrst flags", flags_o, 4'b0000);
    chk("midrst wb_vld", wb_vld_o, 0);
    chk("midrst stall", stall_o, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
